// File: rtl/alu_iter.sv
// Iterative RV32I/RV64I execute unit: single-cycle integer ops with a registered result,
// plus shift-add multiply and restoring divide, one bit per cycle, behind valid/ready handshakes.
module alu_iter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            neg_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_OR     = 5'd6;
  localparam logic [4:0] OP_AND    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0]    MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

  state_e              state_q, state_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic [XLEN-1:0]     mag_q, mag_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                out_valid_q, out_valid_d;

  logic                accept_s;
  logic                is_mul_s, is_div_s, div_zero_s, div_ovf_s, iter_start_s;
  logic                a_sgn_s, b_sgn_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic [SHAMT_W-1:0]  shamt_s;
  logic [XLEN-1:0]     quick_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_shift_s;
  logic                div_ge_s;
  logic [XLEN-1:0]     div_diff_s;
  logic [2*XLEN-1:0]   prod_s, prod_fix_s;
  logic [XLEN-1:0]     div_base_s, fin_res_s;

  assign in_ready_o  = (state_q == S_IDLE) && (!out_valid_q || out_ready_i) && !flush_i;
  assign accept_s    = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = (result_q == '0);
  assign neg_o       = result_q[XLEN-1];
  assign busy_o      = (state_q != S_IDLE);

  // Decode, operand magnitudes and the single-cycle / special-case result.
  always_comb begin
    shamt_s      = b_i[SHAMT_W-1:0];
    is_mul_s     = (op_i >= OP_MUL) && (op_i <= OP_MULHU);
    is_div_s     = (op_i >= OP_DIV) && (op_i <= OP_REMU);
    div_zero_s   = (b_i == '0);
    div_ovf_s    = (a_i == MIN_NEG) && (b_i == '1) && ((op_i == OP_DIV) || (op_i == OP_REM));
    iter_start_s = is_mul_s || (is_div_s && !div_zero_s && !div_ovf_s);
    a_sgn_s      = a_i[XLEN-1] && ((op_i == OP_MUL) || (op_i == OP_MULH) ||
                                   (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM));
    b_sgn_s      = b_i[XLEN-1] && ((op_i == OP_MUL) || (op_i == OP_MULH) ||
                                   (op_i == OP_DIV) || (op_i == OP_REM));
    a_mag_s      = a_sgn_s ? (~a_i + {{(XLEN-1){1'b0}}, 1'b1}) : a_i;
    b_mag_s      = b_sgn_s ? (~b_i + {{(XLEN-1){1'b0}}, 1'b1}) : b_i;
    case (op_i)
      OP_ADD:  quick_s = a_i + b_i;
      OP_SUB:  quick_s = a_i - b_i;
      OP_SLL:  quick_s = a_i << shamt_s;
      OP_SLT:  quick_s = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: quick_s = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  quick_s = a_i ^ b_i;
      OP_OR:   quick_s = a_i | b_i;
      OP_AND:  quick_s = a_i & b_i;
      OP_SRL:  quick_s = a_i >> shamt_s;
      OP_SRA:  quick_s = $unsigned($signed(a_i) >>> shamt_s);
      OP_DIV, OP_DIVU: quick_s = div_zero_s ? '1 : a_i;
      OP_REM, OP_REMU: quick_s = div_zero_s ? a_i : '0;
      default: quick_s = '0;
    endcase
  end

  // Datapath for one multiply/divide step and the final sign correction.
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
    div_shift_s = {hi_q, lo_q[XLEN-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mag_q});
    div_diff_s  = XLEN'(div_shift_s - {1'b0, mag_q});
    prod_s      = {hi_q, lo_q};
    prod_fix_s  = neg_q ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
    div_base_s  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? lo_q : hi_q;
    if (op_q <= OP_MULHU) begin
      fin_res_s = (op_q == OP_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
    end else begin
      fin_res_s = neg_q ? (~div_base_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_base_s;
    end
  end

  // Next-state logic: accept, iterate, finish; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mag_d       = mag_q;
    op_d        = op_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
          if (accept_s && iter_start_s) begin
            state_d = is_mul_s ? S_MUL : S_DIV;
            cnt_d   = CNT_LAST;
            hi_d    = '0;
            lo_d    = is_mul_s ? b_mag_s : a_mag_s;
            mag_d   = is_mul_s ? a_mag_s : b_mag_s;
            op_d    = op_i;
            neg_d   = (op_i == OP_REM) ? a_sgn_s : (a_sgn_s ^ b_sgn_s);
          end else if (accept_s) begin
            result_d    = quick_s;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (state_q == S_MUL) begin
            hi_d = mul_sum_s[XLEN:1];
            lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
          end else begin
            hi_d = div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge_s};
          end
          if (cnt_q == '0) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
          end
        end
        S_FIN: begin
          result_d    = fin_res_s;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mag_q       <= '0;
      op_q        <= 5'd0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mag_q       <= mag_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (XLEN=32): directed cases plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_alu_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [4:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            neg_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles left on a long op, pending result, visible result.
  int          m_cnt;
  logic [31:0] m_pend;
  logic [31:0] m_res;
  logic        m_valid;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .zero_o(zero_o), .neg_o(neg_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a | b;
      5'd7:  return a & b;
      5'd8:  return a >> b[4:0];
      5'd9:  return $unsigned(sa >>> b[4:0]);
      5'd10: return a * b;
      5'd11: begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
      5'd12: begin sp = 64'(sa) * $signed({32'd0, b}); return sp[63:32]; end
      5'd13: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $unsigned(sa / sb);
      end
      5'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $unsigned(sa % sb);
      end
      5'd17: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_long(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd10 && op <= 5'd13) return 1'b1;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 32'd0) return 1'b0;
      if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return (m_cnt == 0) && (!m_valid || out_ready_i) && !flush_i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pend = 32'd0; m_res = 32'd0; m_valid = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs presented during the cycle.
  task automatic model_edge();
    bit acc;
    acc = in_valid_i && m_ready();
    if (flush_i) begin
      m_cnt = 0;
      m_valid = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_res = m_pend;
        m_valid = 1'b1;
      end
    end else begin
      if (m_valid && out_ready_i) m_valid = 1'b0;
      if (acc) begin
        if (is_long(op_i, a_i, b_i)) begin
          m_cnt = XLEN + 1;
          m_pend = ref_op(op_i, a_i, b_i);
        end else begin
          m_res = ref_op(op_i, a_i, b_i);
          m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid_o), 64'(m_valid));
    chk("in_ready",  64'(in_ready_o),  64'(m_ready()));
    chk("busy",      64'(busy_o),      64'(m_cnt > 0));
    chk("result",    64'(result_o),    64'(m_res));
    chk("zero",      64'(zero_o),      64'(m_res == 32'd0));
    chk("neg",       64'(neg_o),       64'(m_res[31]));
  endtask

  // One clock: compare mid-cycle, then step the model on the edge; returns at the falling edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    while (!acc && n < 100) begin
      acc = m_ready();
      tick();
      n++;
    end
    in_valid_i = 1'b0;
    if (!acc) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk(name, 64'(result_o), 64'(exp));
    tick();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; op_i = 5'd0;
    a_i = 32'd0; b_i = 32'd0; out_ready_i = 1'b1;
    model_reset();

    // Pin the reference model itself with hand-computed values.
    chk("ref_mulhsu", 64'(ref_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'h0000_0000_FFFF_FFFF);
    chk("ref_div",    64'(ref_op(5'd14, 32'hFFFF_FFF9, 32'd2)),         64'h0000_0000_FFFF_FFFD);
    chk("ref_remu",   64'(ref_op(5'd17, 32'd100, 32'd7)),               64'h0000_0000_0000_0002);
    chk("ref_op31",   64'(ref_op(5'd31, 32'd5, 32'd6)),                 64'h0);

    @(negedge clk);
    #1;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_zero",  64'(zero_o), 64'd1);
    chk("rst_busy",  64'(busy_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    run_op("slt",     5'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu",    5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sra",     5'd9, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
    run_op("mulh",    5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 34);
    run_op("mulhu",   5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mul",     5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34);
    run_op("div_z",   5'd14, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("div_neg", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_neg", 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);

    // Backpressure: result must hold and the unit must refuse input.
    out_ready_i = 1'b0;
    issue(5'd0, 32'd5, 32'd6);
    in_valid_i = 1'b1; op_i = 5'd0; a_i = 32'd1; b_i = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_result", 64'(result_o), 64'd11);
      chk("hold_ready",  64'(in_ready_o), 64'd0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();

    // Back-to-back single-cycle ops, one result per cycle.
    in_valid_i = 1'b1; op_i = 5'd0; b_i = 32'd10;
    for (int k = 0; k < 4; k++) begin
      a_i = 32'(k);
      tick();
      chk("b2b_valid",  64'(out_valid_o), 64'd1);
      chk("b2b_result", 64'(result_o), 64'(k + 10));
    end
    in_valid_i = 1'b0;
    tick();

    // Flush part way through a DIVU.
    issue(5'd15, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 40; i++) tick();

    // Asynchronous reset in the middle of a MUL.
    run_op("pre_rst", 5'd6, 32'h8000_0000, 32'd3, 32'h8000_0003, 1);
    issue(5'd10, 32'd9, 32'd9);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  64'(out_valid_o), 64'd0);
    chk("arst_result", 64'(result_o), 64'd0);
    chk("arst_zero",   64'(zero_o), 64'd1);
    chk("arst_neg",    64'(neg_o), 64'd0);
    chk("arst_busy",   64'(busy_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      op_i = 5'($urandom_range(0, 9));
      else if (r < 65) op_i = 5'($urandom_range(18, 31));
      else             op_i = 5'($urandom_range(10, 17));
      a_i = pick_operand();
      b_i = pick_operand();
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 59) == 0);
      tick();
    end
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
